// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending controller with saturating credit and unit-coin change return.
// Define VM_STOCK_EN to enable per-item stock counters with restock.
module vending_machine_multi #(
  parameter int NUM_ITEMS   = 4,
  parameter int ITEM_W      = 2,
  parameter int PRICE_BASE  = 6,
  parameter int PRICE_STEP  = 2,
  parameter int COIN_LO     = 2,
  parameter int COIN_HI     = 10,
  parameter int CHANGE_UNIT = 2,
  parameter int CREDIT_W    = 6,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in_en,
  input  logic                coin_val,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel_id,
  input  logic                cancel,
  input  logic                restock,
  input  logic [ITEM_W-1:0]   restock_id,
  output logic                item_out,
  output logic [ITEM_W-1:0]   item_id_out,
  output logic                change_out,
  output logic                coin_reject,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ACCEPT, VEND, CHANGE} state_t;
  localparam int MAX_CREDIT = 2**CREDIT_W - 1;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [ITEM_W-1:0] item_id_n;
  logic reject_n, sold_n, vend_go, in_range, has_stock;
  int coin_v, price;
  assign coin_v = coin_val ? COIN_HI : COIN_LO;
  assign price = PRICE_BASE + int'(sel_id) * PRICE_STEP;
  assign in_range = int'(sel_id) < NUM_ITEMS;
`ifdef VM_STOCK_EN
  logic [STOCK_W-1:0] stock [NUM_ITEMS];
  assign has_stock = in_range && stock[sel_id] != '0;
  // restock is applied last so it overrides a same-cycle decrement
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_ITEMS; i++)
      if (rst || (restock && int'(restock_id) == i)) stock[i] <= STOCK_W'(STOCK_INIT);
      else if (vend_go && int'(sel_id) == i) stock[i] <= stock[i] - STOCK_W'(1);
`else
  logic unused_restock;
  localparam int unused_stock_cfg = STOCK_W + STOCK_INIT;
  assign unused_restock = ^{restock, restock_id};
  assign has_stock = in_range;
`endif
  always_comb begin
    state_n = state;
    credit_n = credit;
    item_id_n = item_id_out;
    reject_n = coin_in_en;
    sold_n = 1'b0;
    vend_go = 1'b0;
    if (state == VEND) state_n = credit == '0 ? IDLE : CHANGE;
    else if (state == CHANGE) begin
      credit_n = credit - CREDIT_W'(CHANGE_UNIT);
      state_n = int'(credit) <= CHANGE_UNIT ? IDLE : CHANGE;
    end else if (cancel && state == ACCEPT) state_n = CHANGE;
    else if (sel_valid && state == ACCEPT) begin
      sold_n = !has_stock;
      if (has_stock && int'(credit) >= price) begin
        vend_go = 1'b1;
        state_n = VEND;
        credit_n = credit - CREDIT_W'(price);
        item_id_n = sel_id;
      end
    end else if (coin_in_en && !cancel && !sel_valid && int'(credit) + coin_v <= MAX_CREDIT) begin
      reject_n = 1'b0;
      credit_n = credit + CREDIT_W'(coin_v);
      state_n = ACCEPT;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      credit <= '0;
      item_out <= 1'b0;
      item_id_out <= '0;
      change_out <= 1'b0;
      coin_reject <= 1'b0;
      sold_out <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      item_out <= state_n == VEND;
      item_id_out <= item_id_n;
      change_out <= state_n == CHANGE;
      coin_reject <= reject_n;
      sold_out <= sold_n;
      busy <= state_n == VEND || state_n == CHANGE;
    end
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed test-plan scenarios plus random traffic against a credit/refund-count model.
module tb_vending_machine_multi;
  localparam int N = 4, U = 2, MAXC = 63;
`ifdef VM_STOCK_EN
  localparam int SI = 1;
`else
  localparam int SI = 8;
`endif
  logic clk = 0, rst = 1, coin_in_en = 0, coin_val = 0, sel_valid = 0, cancel = 0, restock = 0;
  logic [1:0] sel_id = 0, restock_id = 0, item_id_out;
  logic item_out, change_out, coin_reject, sold_out, busy;
  logic [5:0] credit;
  int checks = 0, errors = 0;
  int m_credit, m_refund, m_id, m_stock [N];
  bit m_vend, e_reject, e_sold;
  always #5 clk = ~clk;
  vending_machine_multi #(.STOCK_INIT(SI)) dut (
    .clk(clk), .rst(rst), .coin_in_en(coin_in_en), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .restock(restock),
    .restock_id(restock_id), .item_out(item_out), .item_id_out(item_id_out),
    .change_out(change_out), .coin_reject(coin_reject), .sold_out(sold_out),
    .credit(credit), .busy(busy)
  );
  task automatic check(string tag, logic [31:0] got, int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // The model keeps credit plus the number of change pulses still owed.
  task automatic model_step();
    bit coin_ok = 0, empty;
    int v = coin_val ? 10 : 2;
    int id = int'(sel_id);
    e_sold = 0;
    if (rst) begin
      m_credit = 0; m_refund = 0; m_vend = 0; m_id = 0; e_reject = 0;
      foreach (m_stock[i]) m_stock[i] = SI;
      return;
    end
`ifdef VM_STOCK_EN
    empty = id >= N || m_stock[id] == 0;
`else
    empty = id >= N;
`endif
    if (m_vend) begin
      m_vend = 0;
      m_refund = m_credit / U;
    end else if (m_refund > 0) begin
      m_credit -= U;
      m_refund--;
    end else if (m_credit > 0 && cancel) m_refund = m_credit / U;
    else if (m_credit > 0 && sel_valid) begin
      if (empty) e_sold = 1;
      else if (m_credit >= 6 + 2 * id) begin
        m_credit -= 6 + 2 * id;
        m_vend = 1;
        m_id = id;
        m_stock[id]--;
      end
    end else if (coin_in_en && !cancel && !sel_valid && m_credit + v <= MAXC) begin
      m_credit += v;
      coin_ok = 1;
    end
    e_reject = coin_in_en && !coin_ok;
`ifdef VM_STOCK_EN
    if (restock && int'(restock_id) < N) m_stock[restock_id] = SI;
`endif
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("credit", credit, m_credit);
    check("item_out", item_out, int'(m_vend));
    check("item_id_out", item_id_out, m_id);
    check("change_out", change_out, int'(m_refund > 0));
    check("coin_reject", coin_reject, int'(e_reject));
    check("sold_out", sold_out, int'(e_sold));
    check("busy", busy, int'(m_vend || m_refund > 0));
  endtask
  task automatic op(bit c, bit cv, bit s, int id, bit cn);
    coin_in_en = c; coin_val = cv; sel_valid = s; sel_id = 2'(id); cancel = cn;
    step();
    coin_in_en = 0; coin_val = 0; sel_valid = 0; sel_id = 0; cancel = 0;
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  initial begin
    idle(2);
    rst = 0;
    idle(1);
    repeat (3) op(1, 0, 0, 0, 0);
    op(0, 0, 1, 0, 0);
    idle(3);
    op(1, 1, 0, 0, 0);
    op(0, 0, 1, 1, 0);
    idle(3);
    op(1, 1, 0, 0, 0);
    op(1, 0, 0, 0, 0);
    op(1, 0, 0, 0, 1);
    idle(8);
    repeat (7) op(1, 1, 0, 0, 0);
    op(0, 0, 1, 3, 0);
    idle(27);
    op(1, 1, 0, 0, 0);
    op(0, 0, 1, 2, 0);
    idle(2);
    op(1, 1, 0, 0, 0);
    op(0, 0, 1, 2, 0);
    restock = 1; restock_id = 2;
    step();
    restock = 0; restock_id = 0;
    op(0, 0, 1, 2, 0);
    idle(2);
    op(1, 1, 0, 0, 0);
    op(0, 0, 0, 0, 1);
    idle(2);
    rst = 1;
    step();
    rst = 0;
    idle(6);
    for (int k = 0; k < 4000; k++) begin
      coin_in_en = $urandom_range(2) == 0;
      coin_val = 1'($urandom);
      sel_valid = $urandom_range(5) == 0;
      sel_id = 2'($urandom);
      cancel = $urandom_range(24) == 0;
      restock = $urandom_range(39) == 0;
      restock_id = 2'($urandom);
      rst = $urandom_range(499) == 0;
      step();
    end
    rst = 0; coin_in_en = 0; sel_valid = 0; cancel = 0; restock = 0;
    idle(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
